// File: rtl/rf_write_arbiter_if.sv
// Writeback request/grant bundle for the register-file write arbiter.
// Carries the two requester handshakes and the register-file write port.
interface rf_write_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          alu_valid;
   logic [AW-1:0] alu_reg;
   logic [DW-1:0] alu_data;
   logic          alu_ready;

   logic          mem_valid;
   logic [AW-1:0] mem_reg;
   logic [DW-1:0] mem_data;
   logic          mem_ready;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   // master = requesters plus register file; slave = the arbiter
   modport master (
      output alu_valid, alu_reg, alu_data,
      input  alu_ready,
      output mem_valid, mem_reg, mem_data,
      input  mem_ready,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      output alu_ready,
      input  mem_valid, mem_reg, mem_data,
      output mem_ready,
      output rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with a registered write stage and a contention counter.
module rf_write_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          reset_n,
   rf_write_arbiter_if.slave bus,
   output logic          rr_pri,
   output logic [CW-1:0] conflict_cnt
);
   localparam int NREQ = 2;

   // index 0 = ALU, index 1 = MEM
   logic [NREQ-1:0]         req_vld;
   logic [NREQ-1:0][AW-1:0] req_reg;
   logic [NREQ-1:0][DW-1:0] req_dat;
   logic [NREQ-1:0]         gnt;
   logic                    sel;
   logic                    any_gnt;

   logic          we_q;
   logic [AW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;

   assign req_vld = {bus.mem_valid, bus.alu_valid};
   assign req_reg = {bus.mem_reg,   bus.alu_reg};
   assign req_dat = {bus.mem_data,  bus.alu_data};

   // A requester wins when alone, or when both ask and it holds priority.
   // Gating with reset_n keeps both readys low while reset is asserted.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = reset_n & req_vld[gi] &
                       (~req_vld[NREQ-1-gi] | (rr_pri == 1'(gi)));
   end

   assign sel     = gnt[1];
   assign any_gnt = |gnt;

   assign bus.alu_ready = gnt[0];
   assign bus.mem_ready = gnt[1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         rr_pri       <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         // $0 requests complete the handshake but never raise the write enable
         we_q <= any_gnt && (req_reg[sel] != '0);
         if (any_gnt) begin
            waddr_q <= req_reg[sel];
            wdata_q <= req_dat[sel];
            rr_pri  <= ~sel;
         end
         if ((&req_vld) && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a queue-based
// requester/register-file reference model.
module tb_rf_write_arbiter;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rr_pri, rr_pri4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   rf_write_arbiter_if #(.DW(32), .AW(5)) b ();
   rf_write_arbiter_if #(.DW(32), .AW(5)) b4 ();

   rf_write_arbiter #(.DW(32), .AW(5), .CW(16)) dut (
      .clock(clock), .reset_n(reset_n), .bus(b.slave),
      .rr_pri(rr_pri), .conflict_cnt(cnt));

   rf_write_arbiter #(.DW(32), .AW(5), .CW(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .bus(b4.slave),
      .rr_pri(rr_pri4), .conflict_cnt(cnt4));

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } req_t;

   req_t        aq[$], mq[$];
   req_t        wlog[$];
   int          m_pri, m_cnt;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [31:0] rf_exp[32], rf_obs[32];
   int          ntest, nfail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      b.alu_valid = (aq.size() > 0);
      b.alu_reg   = (aq.size() > 0) ? aq[0].r : 5'd0;
      b.alu_data  = (aq.size() > 0) ? aq[0].d : 32'd0;
      b.mem_valid = (mq.size() > 0);
      b.mem_reg   = (mq.size() > 0) ? mq[0].r : 5'd0;
      b.mem_data  = (mq.size() > 0) ? mq[0].d : 32'd0;
   endtask

   // One clock: drive queue heads, check readys, then the registered results.
   task automatic step();
      bit   av, mv, ga, gm;
      req_t w;
      drive();
      #1;
      av = (aq.size() > 0);
      mv = (mq.size() > 0);
      ga = av && (!mv || m_pri == 0);
      gm = mv && (!av || m_pri == 1);
      chk("alu_ready", b.alu_ready, ga);
      chk("mem_ready", b.mem_ready, gm);
      chk("one_ready", b.alu_ready & b.mem_ready, 0);
      @(posedge clock);
      if (av && mv && m_cnt < 65535) m_cnt++;
      m_we = 1'b0;
      if (ga || gm) begin
         if (ga) begin w = aq.pop_front(); m_pri = 1; end
         else    begin w = mq.pop_front(); m_pri = 0; end
         m_we = (w.r != 0);
         m_wa = w.r;
         m_wd = w.d;
         if (m_we) rf_exp[w.r] = w.d;
      end
      #1;
      chk("rf_we", b.rf_we, m_we);
      chk("rf_waddr", b.rf_waddr, m_wa);
      chk("rf_wdata", b.rf_wdata, m_wd);
      chk("rr_pri", rr_pri, m_pri);
      chk("conflict_cnt", cnt, 64'(m_cnt));
      if (b.rf_we) begin
         rf_obs[b.rf_waddr] = b.rf_wdata;
         wlog.push_back('{b.rf_waddr, b.rf_wdata});
      end
      @(negedge clock);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 64 && (aq.size() + mq.size()) > 0; i++) step();
      chk(tag, aq.size() + mq.size(), 0);
   endtask

   initial begin
      ntest = 0; nfail = 0;
      m_pri = 0; m_cnt = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      for (int i = 0; i < 32; i++) begin rf_exp[i] = '0; rf_obs[i] = '0; end
      b.alu_valid = 1'b0; b.alu_reg = '0; b.alu_data = '0;
      b.mem_valid = 1'b0; b.mem_reg = '0; b.mem_data = '0;
      b4.alu_valid = 1'b0; b4.alu_reg = 5'd7; b4.alu_data = 32'h7;
      b4.mem_valid = 1'b0; b4.mem_reg = 5'd9; b4.mem_data = 32'h9;

      // Reset: readys stay low even with requests present
      #1 b.alu_valid = 1'b1; b.mem_valid = 1'b1;
      #1;
      chk("rst_alu_ready", b.alu_ready, 0);
      chk("rst_mem_ready", b.mem_ready, 0);
      repeat (2) @(posedge clock);
      #1;
      chk("rst_rf_we", b.rf_we, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_pri", rr_pri, 0);
      @(negedge clock);
      b.alu_valid = 1'b0; b.mem_valid = 1'b0;
      reset_n = 1'b1;
      repeat (10) step();

      // Single ALU write, then idle
      aq.push_back('{5'd8, 32'h1234_5678});
      step();
      step();

      // MEM write to $0: handshake completes, no write enable, priority back to ALU
      mq.push_back('{5'd0, 32'hFFFF_FFFF});
      step();
      chk("r0_waddr", b.rf_waddr, 0);
      chk("r0_pri", rr_pri, 0);

      // Contention alternation
      wlog.delete();
      aq.push_back('{5'd1, 32'hA1}); aq.push_back('{5'd2, 32'hA2});
      mq.push_back('{5'd9, 32'hB9}); mq.push_back('{5'd10, 32'hBA});
      repeat (4) step();
      chk("alt_drained", aq.size() + mq.size(), 0);
      chk("alt_nwrites", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("alt_w0", wlog[0].r, 1);
         chk("alt_w1", wlog[1].r, 9);
         chk("alt_w2", wlog[2].r, 2);
         chk("alt_w3", wlog[3].r, 10);
      end
      chk("alt_cnt", cnt, 3);

      // Same destination: ALU first, MEM lands last
      wlog.delete();
      aq.push_back('{5'd5, 32'h11});
      mq.push_back('{5'd5, 32'h22});
      drain("same_drain");
      chk("same_nwrites", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("same_d0", wlog[0].d, 32'h11);
         chk("same_d1", wlog[1].d, 32'h22);
      end
      chk("same_final", rf_obs[5], 32'h22);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if (aq.size() == 0 && $urandom_range(2, 0) == 0)
            aq.push_back('{5'($urandom_range(31, 0)), 32'($urandom)});
         if (mq.size() == 0 && $urandom_range(2, 0) == 0)
            mq.push_back('{5'($urandom_range(31, 0)), 32'($urandom)});
         step();
      end
      drain("rand_drain");
      for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), rf_obs[i], rf_exp[i]);

      // Narrow counter saturates
      b4.alu_valid = 1'b1; b4.mem_valid = 1'b1;
      repeat (10) @(posedge clock);
      #1 chk("sat_cnt10", cnt4, 10);
      repeat (10) @(posedge clock);
      #1 chk("sat_cnt15", cnt4, 15);
      @(negedge clock);
      b4.alu_valid = 1'b0; b4.mem_valid = 1'b0;
      m_we = 1'b0;

      // Async reset in the middle of a grant cycle
      aq.push_back('{5'd3, 32'hC3});
      step();
      chk("pre_rst_we", b.rf_we, 1);
      aq.push_back('{5'd4, 32'hC4});
      drive();
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_we", b.rf_we, 0);
      chk("mid_rst_ready", b.alu_ready, 0);
      chk("mid_rst_pri", rr_pri, 0);
      chk("mid_rst_cnt", cnt, 0);
      aq.delete();
      b.alu_valid = 1'b0;
      @(posedge clock);
      #1 chk("rst_hold_we", b.rf_we, 0);
      @(negedge clock);
      reset_n = 1'b1;
      m_pri = 0; m_cnt = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
